send_data_arbiter: RTL and testbench

Parametrised successor to the fixed three-channel game-state/target/operate sender. It sits between the game-logic producers and the UART transmitter. It collects CHANNELS byte-wide status channels and arbitrates them round-robin onto one byte stream with a valid/ready handshake. It supports continuous or send-on-change scheduling, guarantees that 8'h00 never reaches the UART, and flags channel overruns.

---
 rtl/send_data_arbiter.sv | 185 ++++++++++++++++++
 tb/tb_send_data_arbiter.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/send_data_arbiter.sv
// send_data_arbiter
// Collects CHANNELS status bytes and serialises them round-robin onto a single
// valid/ready byte stream for the UART transmitter. In send-on-change mode only
// channels whose value moved are offered. Lost intermediate values are flagged
// per channel. An all-zero byte is never offered; ZERO_SUB is sent instead.
module send_data_arbiter #(
    parameter int               CHANNELS = 3,
    parameter int               WIDTH    = 8,
    parameter int               MODE     = 0,
    parameter logic [WIDTH-1:0] ZERO_SUB = 8'hFF,
    localparam int              CW       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      uart_clk,
    input  logic                      rst,
    input  logic [CHANNELS*WIDTH-1:0] data_in,
    input  logic                      tx_ready,
    output logic [WIDTH-1:0]          tx_data,
    output logic                      tx_valid,
    output logic [CW-1:0]             tx_chan,
    output logic [CHANNELS-1:0]       overrun
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_t;

    state_t               state_r;
    logic [CW-1:0]        ptr_r;
    logic [WIDTH-1:0]     tx_data_r;
    logic                 tx_valid_r;
    logic [CW-1:0]        tx_chan_r;
    logic [CHANNELS-1:0]  overrun_r;

    logic [WIDTH-1:0]     snap_r      [CHANNELS];
    logic [WIDTH-1:0]     last_seen_r [CHANNELS];
    logic [CHANNELS-1:0]  pending_r;
    // Set when the channel's value moved while an older value of that channel
    // was being offered, so the newer value is still owed after the accept.
    logic [CHANNELS-1:0]  stale_r;

    logic [WIDTH-1:0]     din_s [CHANNELS];
    logic [CHANNELS-1:0]  eligible_s;
    logic [CHANNELS-1:0]  change_s;
    logic [CHANNELS-1:0]  load_vec_s;
    logic [CHANNELS-1:0]  acc_vec_s;
    logic [CHANNELS-1:0]  busy_vec_s;
    logic                 grant_valid_s;
    logic [CW-1:0]        grant_chan_s;
    logic                 accept_s;
    logic                 load_s;
    logic [CW-1:0]        next_ptr_s;
    logic [WIDTH-1:0]     load_byte_s;

    assign tx_data  = tx_data_r;
    assign tx_valid = tx_valid_r;
    assign tx_chan  = tx_chan_r;
    assign overrun  = overrun_r;

    // Split the flat input bus into per-channel bytes.
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            din_s[i] = data_in[i*WIDTH +: WIDTH];
        end
    end

    // Per-channel control terms: change, load, accept and in-flight status.
    always_comb begin
        eligible_s = (MODE == 0) ? {CHANNELS{1'b1}} : pending_r;
        accept_s   = tx_valid_r & tx_ready;
        load_s     = (state_r == ST_IDLE) & grant_valid_s;
        for (int i = 0; i < CHANNELS; i++) begin
            change_s[i]   = (din_s[i] != last_seen_r[i]);
            load_vec_s[i] = load_s && (grant_chan_s == CW'(i));
            acc_vec_s[i]  = accept_s && (tx_chan_r == CW'(i));
            busy_vec_s[i] = (state_r == ST_SEND) && (tx_chan_r == CW'(i));
        end
    end

    // Round-robin scan starting at ptr for the first eligible channel.
    always_comb begin
        int idx;
        idx           = 0;
        grant_valid_s = 1'b0;
        grant_chan_s  = {CW{1'b0}};
        for (int k = 0; k < CHANNELS; k++) begin
            idx = int'(ptr_r) + k;
            idx = (idx >= CHANNELS) ? (idx - CHANNELS) : idx;
            if (!grant_valid_s && eligible_s[idx]) begin
                grant_valid_s = 1'b1;
                grant_chan_s  = CW'(idx);
            end else begin
                grant_valid_s = grant_valid_s;
            end
        end
    end

    // Byte to load and the pointer that follows the channel being accepted.
    // Continuous mode samples the live input so the first byte after reset is
    // the real value rather than the cleared snapshot.
    always_comb begin
        if (MODE == 0) begin
            load_byte_s = din_s[grant_chan_s];
        end else begin
            load_byte_s = snap_r[grant_chan_s];
        end
        if (tx_chan_r == CW'(CHANNELS - 1)) begin
            next_ptr_s = {CW{1'b0}};
        end else begin
            next_ptr_s = tx_chan_r + CW'(1);
        end
    end

    // Two-state transmit FSM with registered handshake outputs.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ptr_r      <= {CW{1'b0}};
            tx_data_r  <= {WIDTH{1'b0}};
            tx_valid_r <= 1'b0;
            tx_chan_r  <= {CW{1'b0}};
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (grant_valid_s) begin
                        tx_data_r  <= (load_byte_s == {WIDTH{1'b0}}) ? ZERO_SUB : load_byte_s;
                        tx_chan_r  <= grant_chan_s;
                        tx_valid_r <= 1'b1;
                        state_r    <= ST_SEND;
                    end else begin
                        tx_valid_r <= 1'b0;
                    end
                end
                ST_SEND: begin
                    if (accept_s) begin
                        tx_valid_r <= 1'b0;
                        ptr_r      <= next_ptr_s;
                        state_r    <= ST_IDLE;
                    end else begin
                        state_r    <= ST_SEND;
                    end
                end
                default: begin
                    tx_valid_r <= 1'b0;
                    state_r    <= ST_IDLE;
                end
            endcase
        end
    end

    // Per-channel snapshot, change detection, pending and overrun tracking.
    always_ff @(posedge uart_clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < CHANNELS; i++) begin
                snap_r[i]      <= {WIDTH{1'b0}};
                last_seen_r[i] <= {WIDTH{1'b0}};
            end
            pending_r <= {CHANNELS{1'b0}};
            stale_r   <= {CHANNELS{1'b0}};
            overrun_r <= {CHANNELS{1'b0}};
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (MODE == 0) begin
                    snap_r[i] <= din_s[i];
                end else begin
                    if (change_s[i]) begin
                        last_seen_r[i] <= din_s[i];
                        snap_r[i]      <= din_s[i];
                    end
                    if (acc_vec_s[i]) begin
                        pending_r[i] <= change_s[i] | stale_r[i];
                        stale_r[i]   <= 1'b0;
                    end else if (change_s[i]) begin
                        pending_r[i] <= 1'b1;
                        stale_r[i]   <= stale_r[i] | load_vec_s[i] | busy_vec_s[i];
                        if (pending_r[i]) begin
                            overrun_r[i] <= 1'b1;
                        end
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_send_data_arbiter.sv
// Directed bench for send_data_arbiter: one continuous-mode instance and one
// send-on-change instance share clock and reset.
module tb_send_data_arbiter;

    localparam int CH = 3;
    localparam int W  = 8;
    localparam int CW = 2;

    logic            uart_clk = 1'b0;
    logic            rst;
    logic [CH*W-1:0] data0, data1;
    logic            ready0, ready1;
    logic [W-1:0]    txd0, txd1;
    logic            txv0, txv1;
    logic [CW-1:0]   txc0, txc1;
    logic [CH-1:0]   ovr0, ovr1;

    int errors = 0;
    int checks = 0;

    always #5 uart_clk = ~uart_clk;

    send_data_arbiter #(.CHANNELS(CH), .WIDTH(W), .MODE(0), .ZERO_SUB(8'hFF)) u_cont (
        .uart_clk (uart_clk),
        .rst      (rst),
        .data_in  (data0),
        .tx_ready (ready0),
        .tx_data  (txd0),
        .tx_valid (txv0),
        .tx_chan  (txc0),
        .overrun  (ovr0)
    );

    send_data_arbiter #(.CHANNELS(CH), .WIDTH(W), .MODE(1), .ZERO_SUB(8'hFF)) u_chg (
        .uart_clk (uart_clk),
        .rst      (rst),
        .data_in  (data1),
        .tx_ready (ready1),
        .tx_data  (txd1),
        .tx_valid (txv1),
        .tx_chan  (txc1),
        .overrun  (ovr1)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge uart_clk);
        @(negedge uart_clk);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic expect_byte1(input string tag, input logic [7:0] d, input logic [1:0] c);
        check({tag, "_valid"}, 32'(txv1), 32'd1);
        check({tag, "_data"},  32'(txd1), 32'(d));
        check({tag, "_chan"},  32'(txc1), 32'(c));
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    initial begin
        logic [7:0] seq_d [4];
        seq_d = '{8'h11, 8'h22, 8'h33, 8'h11};
        rst    = 1'b1;
        data0  = {8'h33, 8'h22, 8'h11};
        data1  = {CH*W{1'b0}};
        ready0 = 1'b1;
        ready1 = 1'b1;

        // Reset state of both instances
        @(negedge uart_clk);
        check("rst_valid0", 32'(txv0), 32'd0);
        check("rst_data0",  32'(txd0), 32'd0);
        check("rst_chan0",  32'(txc0), 32'd0);
        check("rst_ovr0",   32'(ovr0), 32'd0);
        check("rst_valid1", 32'(txv1), 32'd0);
        check("rst_ovr1",   32'(ovr1), 32'd0);
        tick();
        rst = 1'b0;

        // Continuous round robin: 11,22,33,11 every other cycle
        for (int k = 0; k < 4; k++) begin
            tick();
            check("cont_valid", 32'(txv0), 32'd1);
            check("cont_data",  32'(txd0), 32'(seq_d[k]));
            check("cont_chan",  32'(txc0), 32'(k % 3));
            tick();
            check("cont_gap",   32'(txv0), 32'd0);
        end
        check("cont_ovr", 32'(ovr0), 32'd0);

        // Continuous mode, zero byte on channel 1 is substituted
        data0 = {8'h33, 8'h00, 8'h11};
        do_reset();
        tick();
        check("zs_first", 32'(txd0), 32'h11);
        tick();
        tick();
        check("zs_valid", 32'(txv0), 32'd1);
        check("zs_data",  32'(txd0), 32'hFF);
        check("zs_chan",  32'(txc0), 32'd1);
        for (int k = 0; k < 6; k++) begin
            tick();
            check("zs_nonzero", 32'(txv0 && (txd0 == 8'h00)), 32'd0);
        end

        // Send-on-change: only channel 2 changes
        data1  = {CH*W{1'b0}};
        ready1 = 1'b1;
        do_reset();
        tick();
        check("soc_quiet", 32'(txv1), 32'd0);
        data1 = {8'h5A, 8'h00, 8'h00};
        tick();
        check("soc_e0", 32'(txv1), 32'd0);
        tick();
        expect_byte1("soc_e1", 8'h5A, 2'd2);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("soc_idle", 32'(txv1), 32'd0);
        end
        check("soc_ovr", 32'(ovr1), 32'd0);

        // Send-on-change with back-pressure: 01 -> 02 -> 03 on channel 0
        data1  = {CH*W{1'b0}};
        ready1 = 1'b0;
        do_reset();
        data1 = {8'h00, 8'h00, 8'h01};
        tick();
        data1 = {8'h00, 8'h00, 8'h02};
        tick();
        expect_byte1("ovr_load", 8'h01, 2'd0);
        data1 = {8'h00, 8'h00, 8'h03};
        tick();
        tick();
        tick();
        expect_byte1("ovr_hold", 8'h01, 2'd0);
        check("ovr_flag", 32'(ovr1), 32'h1);
        ready1 = 1'b1;
        tick();
        check("ovr_acc", 32'(txv1), 32'd0);
        tick();
        expect_byte1("ovr_newest", 8'h03, 2'd0);
        tick();
        tick();
        check("ovr_done", 32'(txv1), 32'd0);
        check("ovr_sticky", 32'(ovr1), 32'h1);

        // Three simultaneous changes with ptr=1, then a change during accept
        data1 = {8'hC3, 8'hB2, 8'hA1};
        tick();
        check("rr_e0", 32'(txv1), 32'd0);
        tick();
        expect_byte1("rr_first", 8'hB2, 2'd1);
        data1 = {8'hC3, 8'hB7, 8'hA1};
        tick();
        check("rr_acc1", 32'(txv1), 32'd0);
        tick();
        expect_byte1("rr_second", 8'hC3, 2'd2);
        tick();
        tick();
        expect_byte1("rr_third", 8'hA1, 2'd0);
        tick();
        tick();
        expect_byte1("rr_resend", 8'hB7, 2'd1);
        tick();
        tick();
        check("rr_idle", 32'(txv1), 32'd0);
        check("rr_ovr", 32'(ovr1), 32'h1);

        // Reset in the middle of a stalled send
        ready1 = 1'b0;
        data1  = {8'hC3, 8'hB7, 8'h05};
        tick();
        tick();
        expect_byte1("mid_load", 8'h05, 2'd0);
        rst = 1'b1;
        #1;
        check("mid_valid", 32'(txv1), 32'd0);
        check("mid_data",  32'(txd1), 32'd0);
        check("mid_chan",  32'(txc1), 32'd0);
        check("mid_ovr",   32'(ovr1), 32'd0);
        tick();
        tick();
        ready1 = 1'b1;
        rst    = 1'b0;
        tick();
        check("post_e0", 32'(txv1), 32'd0);
        tick();
        expect_byte1("post_ch0", 8'h05, 2'd0);
        tick();
        tick();
        expect_byte1("post_ch1", 8'hB7, 2'd1);
        tick();
        tick();
        expect_byte1("post_ch2", 8'hC3, 2'd2);
        tick();
        tick();
        check("post_idle", 32'(txv1), 32'd0);
        check("post_ovr",  32'(ovr1), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
